// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: core-wide widths,
// PC step and the fetch control state encoding.
package fetch_unit_pkg;

  localparam int CORE_XLEN = 32;
  localparam int CORE_PC_W = 10;
  localparam int PC_INC    = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: circular buffer of (instruction, pc) pairs with flush,
// push, pop and occupancy count; the head is presented combinationally.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int PC_W  = CORE_PC_W,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [XLEN-1:0]  push_instr,
  input  logic [PC_W-1:0]  push_pc,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_instr,
  output logic [PC_W-1:0]  out_pc
);

  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [XLEN-1:0]  last_instr;
  logic [PC_W-1:0]  last_pc;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign do_push   = push && !flush;
  assign do_pop    = pop && !flush && (count != '0);
  assign out_valid = (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  // Remember the last presented head so the outputs hold steady when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_instr <= '0;
      last_pc    <= '0;
    end else if (out_valid) begin
      last_instr <= instr_mem[rd_ptr];
      last_pc    <= pc_mem[rd_ptr];
    end
  end

  assign out_instr = out_valid ? instr_mem[rd_ptr] : last_instr;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : last_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, one outstanding imem request,
// redirect flush, halt/drain control and a prefetch queue toward the decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          XLEN     = CORE_XLEN,
  parameter int          PC_W     = CORE_PC_W,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic            halted
);

  localparam int              CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] PC_STEP  = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] PC_ALIGN = ~PC_W'(3);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  resp_pc;
  logic             inflight;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             room;
  logic             resp_push;

  assign pop       = out_valid && out_ready;
  // The outstanding response already owns a slot; a same-cycle pop frees one.
  assign room      = (int'(count) + int'(inflight)) < (DEPTH + int'(pop));
  assign imem_addr = fetch_pc;
  // A response arriving alongside a redirect belongs to the old path.
  assign resp_push = inflight && !redirect_valid;

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    halted     = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (halt) state_next = ST_DRAIN;
        imem_req = reset && !halt && !redirect_valid && room;
      end
      ST_DRAIN: begin
        if (!halt)          state_next = ST_RUN;
        else if (!inflight) state_next = ST_HALTED;
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (!halt) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Request stage: fetch PC, control state and outstanding-request flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      fetch_pc <= PC_W'(RESET_PC);
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= imem_req;
      if (redirect_valid) fetch_pc <= redirect_pc & PC_ALIGN;
      else if (imem_req)  fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) resp_pc <= fetch_pc;
  end

  // Response stage: returning instruction enters the queue tail.
  fetch_queue #(
    .XLEN  (XLEN),
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (resp_push),
    .push_instr (imem_rdata),
    .push_pc    (resp_pc),
    .pop        (pop),
    .count      (count),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, program-order scoreboard and
// directed plus randomized stimulus.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          PC_W     = 10;
  localparam int          DEPTH    = 4;
  localparam int unsigned RESET_PC = 0;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            halt = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_instr;
  logic [PC_W-1:0] out_pc;
  logic            halted;

  int checks = 0;
  int failures = 0;
  int deliv_cnt = 0;
  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] mon_exp;
  logic [PC_W-1:0] last_deliv_pc = '0;
  logic            req_seen = 1'b0;
  logic [PC_W-1:0] addr_seen = '0;

  fetch_unit #(
    .XLEN     (XLEN),
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] mem_word(input logic [PC_W-1:0] a);
    return XLEN'(a >> 2) + XLEN'(32'h100);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) next_cycle();
    sample();
    chk("rst_req",    64'(imem_req),  64'(0));
    chk("rst_vld",    64'(out_valid), 64'(0));
    chk("rst_instr",  64'(out_instr), 64'(0));
    chk("rst_pc",     64'(out_pc),    64'(0));
    chk("rst_halted", 64'(halted),    64'(0));
    next_cycle();
    reset = 1'b1;
  endtask

  // Instruction memory: answers exactly one cycle after a request, garbage otherwise.
  always @(negedge clk) begin
    req_seen  = imem_req;
    addr_seen = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rdata = req_seen ? mem_word(addr_seen) : XLEN'($urandom);
  end

  // Program-order model: sequential PCs from reset or from the latest redirect target.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_q.push_back(PC_W'(RESET_PC));
    end else if (redirect_valid) begin
      exp_q.delete();
      exp_q.push_back(redirect_pc & ~PC_W'(3));
    end
    while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + PC_W'(4));
  end

  // Monitor: every accepted instruction must be the next one in program order.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (imem_req && (halt || redirect_valid || halted || imem_addr[1:0] != 2'b00)) begin
        failures++;
        $display("FAIL req_rule: req=%0b addr=0x%0h halt=%0b redirect=%0b halted=%0b required no request or aligned address",
                 imem_req, imem_addr, halt, redirect_valid, halted);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL deliver: pc=0x%0h arrived with no expectation", out_pc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_pc !== mon_exp || out_instr !== mem_word(mon_exp)) begin
            failures++;
            $display("FAIL deliver: got pc=0x%0h instr=0x%0h expected pc=0x%0h instr=0x%0h",
                     out_pc, out_instr, mon_exp, mem_word(mon_exp));
          end
        end
        last_deliv_pc = out_pc;
        deliv_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    int w;
    int start;
    exp_q.push_back(PC_W'(RESET_PC));

    // Reset release latency and full-rate streaming.
    out_ready = 1'b1;
    apply_reset();
    sample();
    chk("t1_req_c0",  64'(imem_req),  64'(1));
    chk("t1_addr_c0", 64'(imem_addr), 64'(RESET_PC));
    chk("t1_vld_c0",  64'(out_valid), 64'(0));
    next_cycle();
    sample();
    chk("t1_vld_c1",  64'(out_valid), 64'(0));
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      sample();
      chk("t1_vld_stream", 64'(out_valid), 64'(1));
      chk("t1_pc_stream",  64'(out_pc),    64'(PC_W'(RESET_PC + 4 * k)));
      chk("t1_instr",      64'(out_instr), 64'(mem_word(PC_W'(RESET_PC + 4 * k))));
    end

    // Decoder stall: the queue fills and requests stop at DEPTH.
    out_ready = 1'b0;
    apply_reset();
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (imem_req) nreq++;
      next_cycle();
    end
    sample();
    chk("t2_req_total", 64'(nreq),      64'(DEPTH));
    chk("t2_full_vld",  64'(out_valid), 64'(1));
    chk("t2_full_req",  64'(imem_req),  64'(0));
    next_cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("t2_vld_drain", 64'(out_valid), 64'(1));
      chk("t2_pc_drain",  64'(out_pc),    64'(PC_W'(RESET_PC + 4 * k)));
      next_cycle();
    end

    // Redirect with three entries queued and one in flight; target wraps.
    out_ready = 1'b0;
    apply_reset();
    repeat (3) next_cycle();
    sample();
    chk("t3_req_c3", 64'(imem_req), 64'(1));
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3F3;
    sample();
    chk("t3_req_n0", 64'(imem_req),  64'(0));
    chk("t3_vld_n0", 64'(out_valid), 64'(1));
    next_cycle();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    sample();
    chk("t3_vld_n1",  64'(out_valid), 64'(0));
    chk("t3_req_n1",  64'(imem_req),  64'(1));
    chk("t3_addr_n1", 64'(imem_addr), 64'(10'h3F0));
    next_cycle();
    sample();
    chk("t3_vld_n2", 64'(out_valid), 64'(0));
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      sample();
      chk("t3_vld_post", 64'(out_valid), 64'(1));
      chk("t3_pc_post",  64'(out_pc),    64'(PC_W'(10'h3F0 + 4 * k)));
    end
    chk("t3_req_last", 64'(imem_req), 64'(1));

    // Halt with one request in flight, drain, then resume.
    next_cycle();
    halt = 1'b1;
    sample();
    chk("t4_req_h0",    64'(imem_req), 64'(0));
    chk("t4_halted_h0", 64'(halted),   64'(0));
    next_cycle();
    sample();
    chk("t4_req_h1",    64'(imem_req), 64'(0));
    chk("t4_halted_h1", 64'(halted),   64'(0));
    next_cycle();
    sample();
    chk("t4_halted_h2", 64'(halted), 64'(1));
    w = 0;
    while (out_valid && w < 10) begin
      next_cycle();
      sample();
      w++;
    end
    chk("t4_drained", 64'(out_valid), 64'(0));
    repeat (3) begin
      next_cycle();
      sample();
      chk("t4_req_halted", 64'(imem_req), 64'(0));
      chk("t4_halted",     64'(halted),   64'(1));
    end
    next_cycle();
    halt = 1'b0;
    sample();
    chk("t4_halted_m0", 64'(halted),   64'(1));
    chk("t4_req_m0",    64'(imem_req), 64'(0));
    next_cycle();
    sample();
    chk("t4_halted_m1", 64'(halted),    64'(0));
    chk("t4_req_m1",    64'(imem_req),  64'(1));
    chk("t4_addr_m1",   64'(imem_addr), 64'(last_deliv_pc + PC_W'(4)));

    // Redirect coinciding with a pop and an arriving response.
    repeat (4) begin
      next_cycle();
      sample();
    end
    chk("t5_req_pre", 64'(imem_req), 64'(1));
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h2A7;
    sample();
    chk("t5_vld_n0", 64'(out_valid), 64'(1));
    chk("t5_req_n0", 64'(imem_req),  64'(0));
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    chk("t5_vld_n1",  64'(out_valid), 64'(0));
    chk("t5_addr_n1", 64'(imem_addr), 64'(10'h2A4));
    next_cycle();
    sample();
    chk("t5_vld_n2", 64'(out_valid), 64'(0));
    next_cycle();
    sample();
    chk("t5_vld_n3", 64'(out_valid), 64'(1));
    chk("t5_pc_n3",  64'(out_pc),    64'(10'h2A4));

    // Asynchronous reset mid-stream with two entries queued.
    out_ready = 1'b0;
    apply_reset();
    repeat (3) next_cycle();
    sample();
    chk("t6_vld_pre", 64'(out_valid), 64'(1));
    chk("t6_req_pre", 64'(imem_req),  64'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("t6_vld_async", 64'(out_valid), 64'(0));
    chk("t6_req_async", 64'(imem_req),  64'(0));
    chk("t6_pc_async",  64'(out_pc),    64'(0));
    repeat (2) next_cycle();
    reset     = 1'b1;
    out_ready = 1'b1;
    sample();
    chk("t6_addr_c0", 64'(imem_addr), 64'(RESET_PC));
    next_cycle();
    next_cycle();
    sample();
    chk("t6_vld_c2", 64'(out_valid), 64'(1));
    chk("t6_pc_c2",  64'(out_pc),    64'(RESET_PC));

    // Randomized traffic: stalls, redirects and halts.
    for (int k = 0; k < 3000; k++) begin
      next_cycle();
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = PC_W'($urandom);
      if ($urandom_range(0, 49) == 0) halt = ~halt;
    end
    next_cycle();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    out_ready      = 1'b1;
    start = deliv_cnt;
    w = 0;
    while (deliv_cnt < start + 8 && w < 40) begin
      next_cycle();
      w++;
    end
    chk("rand_liveness", 64'(deliv_cnt >= start + 8), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation core.
- Replaces the free-running program counter plus directly wired instruction memory with a PC generator, a one-outstanding-request instruction-memory interface, and a prefetch queue with a valid/ready output handshake.
- Supports branch/jump redirect with flush of stale fetches, and a halt/drain mode.
- Feeds the decoder; the decoder stalls fetch by deasserting out_ready.

Parameters:
- XLEN, 32: instruction word width.
- PC_W, 10: byte-address width of PC; wraps modulo 2^PC_W.
- DEPTH, 4: prefetch queue entries; legal range 2..16.
- RESET_PC, 0: first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  PC_W  byte address of the request; bits [1:0] always 0.
- imem_rdata  in  XLEN  instruction data; valid exactly one cycle after a cycle with imem_req=1.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  PC_W  redirect target; bits [1:0] ignored and forced 0.
- halt  in  1  level; stop issuing new fetches.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decoder accepts the head.
- out_instr  out  XLEN  head instruction.
- out_pc  out  PC_W  address of the head instruction.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC, queue empty, inflight=0, state=RUN.
  - imem_req=0, out_valid=0, out_instr=0, out_pc=0, halted=0.
- States: RUN, DRAIN, HALTED. Each takes effect from the next edge.
  - RUN -> DRAIN when halt=1.
  - DRAIN -> HALTED when inflight=0.
  - DRAIN or HALTED -> RUN when halt=0.
- Issue rule:
  - imem_req = (state==RUN) && !halt && !redirect_valid && (count + inflight - pop < DEPTH).
  - pop = out_valid && out_ready.
  - imem_addr = fetch_pc. On issue, fetch_pc += 4 at the edge, wrapping modulo 2^PC_W.
- Response handling:
  - inflight is set on issue. At the next edge imem_rdata is written to the queue tail together with its PC, unless that response has been flushed.
  - The written entry is visible as out_valid=1 one cycle later.
  - Reset-release latency: request in cycle 0 after release, out_valid=1 in cycle 2.
- Throughput: with out_ready held high and DEPTH>=2, the queue sustains one instruction per cycle.
- Redirect (redirect_valid=1 in cycle N):
  - At the edge: queue emptied, the in-flight response is marked stale and discarded on arrival, fetch_pc=redirect_pc.
  - imem_req=0 in cycle N. Request to redirect_pc in N+1; out_valid=1 with out_pc=redirect_pc in N+3.
  - A pop handshake in cycle N still counts as delivered.
  - Redirect takes priority over an arriving response and over queue writes.
  - A redirect while in DRAIN/HALTED updates fetch_pc and flushes; no fetch occurs until halt=0.
- Queue: circular buffer with pointer wrap at DEPTH.
  - Simultaneous write and pop when full is legal: count unchanged.
  - The issue rule guarantees the queue never overflows.
  - out_valid=0 whenever count=0; out_instr/out_pc hold the last value when empty.
- Halt:
  - An outstanding request completes and is enqueued (unless flushed).
  - Queued instructions continue to drain to the decoder while halted.
- Reset mid-operation discards everything, including any response arriving during or after reset.

Decomposition:
- Shared package: state encoding (RUN/DRAIN/HALTED) and the PC increment constant (4). XLEN/PC_W defaults come from the core-wide constants.
- Sub-module fetch_queue (DEPTH x (XLEN+PC_W) circular FIFO with flush, push, pop, count). Instantiated once.
- PC, issue, and epoch logic stay in fetch_unit.

Test Plan:
- Reset release, out_ready=1, imem returns (addr>>2)+0x100: out_pc sequence 0,4,8,12 on consecutive cycles from cycle 2, out_instr 0x100,0x101,...
- out_ready=0 for 10 cycles, DEPTH=4: queue fills and imem_req drops, so at most 4 requests are issued in total. Then out_ready=1: PCs 0,4,8,12,16 delivered in order with no gaps or duplicates.
- Redirect to 0x3F3 while 3 entries queued and 1 in flight: stale instructions never appear. First out_pc=0x3F0 exactly 3 cycles after redirect, then 0x3F4,0x3F8,0x3FC,0x000 (wrap).
- halt=1 with 1 in flight: DRAIN, then halted=1 next cycle, no further imem_req, queue drains. halt=0: fetch resumes at the next sequential PC.
- Redirect in the same cycle as a pop and an arriving response: popped entry counted once, arriving response discarded, next out_pc=redirect target.
- reset=0 asserted asynchronously mid-stream with 2 queued: out_valid and imem_req fall immediately. After release, first out_pc=RESET_PC.
